// File: rtl/map_table_if.sv
//------------------------------------------------------------------------------
// map_table_if : dispatch / CDB / recovery / CAM-export bundle for map_table
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef ARCH_REGFILE_SIZE
`define ARCH_REGFILE_SIZE 32
`endif
`ifndef PHYS_REGFILE_SIZE
`define PHYS_REGFILE_SIZE 64
`endif

interface map_table_if #(
  parameter int ARCH_SIZE = `ARCH_REGFILE_SIZE,
  parameter int PHYS_SIZE = `PHYS_REGFILE_SIZE,
  parameter int TAG_W     = $clog2(PHYS_SIZE),
  parameter int AR_W      = $clog2(ARCH_SIZE)
);
  logic                             dispatch_en;
  logic [AR_W-1:0]                  dispatch_dest_ar;
  logic [TAG_W-1:0]                 dispatch_new_pr;
  logic [AR_W-1:0]                  rs1_ar;
  logic [AR_W-1:0]                  rs2_ar;
  logic [TAG_W-1:0]                 rs1_pr;
  logic                             rs1_ready;
  logic [TAG_W-1:0]                 rs2_pr;
  logic                             rs2_ready;
  logic [TAG_W-1:0]                 old_pr;
  logic                             cdb_valid;
  logic [TAG_W-1:0]                 cdb_tag;
  logic                             recover_en;
  logic [ARCH_SIZE-1:0][TAG_W-1:0]  arch_map;
  logic [ARCH_SIZE-1:0][TAG_W-1:0]  map_array;
  logic [ARCH_SIZE-1:0]             map_ready;

  modport master (
    output dispatch_en, dispatch_dest_ar, dispatch_new_pr, rs1_ar, rs2_ar,
           cdb_valid, cdb_tag, recover_en, arch_map,
    input  rs1_pr, rs1_ready, rs2_pr, rs2_ready, old_pr, map_array, map_ready
  );

  modport slave (
    input  dispatch_en, dispatch_dest_ar, dispatch_new_pr, rs1_ar, rs2_ar,
           cdb_valid, cdb_tag, recover_en, arch_map,
    output rs1_pr, rs1_ready, rs2_pr, rs2_ready, old_pr, map_array, map_ready
  );
endinterface

`default_nettype wire

// File: rtl/map_table.sv
//------------------------------------------------------------------------------
// map_table : speculative rename map with per-entry ready bits, CDB wakeup and
//             retirement-map recovery. Optional: MAP_TABLE_CDB_FWD_EN.
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef ARCH_REGFILE_SIZE
`define ARCH_REGFILE_SIZE 32
`endif
`ifndef PHYS_REGFILE_SIZE
`define PHYS_REGFILE_SIZE 64
`endif

module map_table #(
  parameter int ARCH_SIZE = `ARCH_REGFILE_SIZE,
  parameter int PHYS_SIZE = `PHYS_REGFILE_SIZE,
  parameter int TAG_W     = $clog2(PHYS_SIZE),
  parameter int AR_W      = $clog2(ARCH_SIZE)
) (
  input  wire logic  clock,
  input  wire logic  reset,
  map_table_if.slave bus
);

  logic [ARCH_SIZE-1:0][TAG_W-1:0] w_map;
  logic [ARCH_SIZE-1:0]            w_ready;
  logic                            w_unused_arch0;

  assign w_unused_arch0 = ^bus.arch_map[0];

  for (genvar i = 0; i < ARCH_SIZE; i++) begin : g_entry
    if (i == 0) begin : g_zero
      // AR 0 is architecturally zero; no storage at all
      assign w_map[i]   = '0;
      assign w_ready[i] = 1'b1;
    end else begin : g_reg
      logic [TAG_W-1:0] r_map;
      logic             r_ready;
      logic             w_disp_hit;
      logic             w_cdb_hit;

      assign w_disp_hit = bus.dispatch_en && (bus.dispatch_dest_ar == AR_W'(i));
      assign w_cdb_hit  = bus.cdb_valid && (r_map == bus.cdb_tag);

      // Recovery beats dispatch, dispatch beats a same-entry CDB wakeup
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_map   <= TAG_W'(i);
          r_ready <= 1'b1;
        end else if (bus.recover_en) begin
          r_map   <= bus.arch_map[i];
          r_ready <= 1'b1;
        end else if (w_disp_hit) begin
          r_map   <= bus.dispatch_new_pr;
          r_ready <= 1'b0;
        end else if (w_cdb_hit) begin
          r_ready <= 1'b1;
        end
      end

      assign w_map[i]   = r_map;
      assign w_ready[i] = r_ready;
    end
  end

  assign bus.map_array = w_map;
  assign bus.map_ready = w_ready;

  assign bus.rs1_pr = w_map[bus.rs1_ar];
  assign bus.rs2_pr = w_map[bus.rs2_ar];
  assign bus.old_pr = w_map[bus.dispatch_dest_ar];

`ifdef MAP_TABLE_CDB_FWD_EN
  assign bus.rs1_ready = w_ready[bus.rs1_ar] |
                         (bus.cdb_valid && (bus.cdb_tag == w_map[bus.rs1_ar]));
  assign bus.rs2_ready = w_ready[bus.rs2_ar] |
                         (bus.cdb_valid && (bus.cdb_tag == w_map[bus.rs2_ar]));
`else
  assign bus.rs1_ready = w_ready[bus.rs1_ar];
  assign bus.rs2_ready = w_ready[bus.rs2_ar];
`endif

endmodule

`default_nettype wire

// File: tb/tb_map_table.sv
//------------------------------------------------------------------------------
// tb_map_table : directed scoreboard bench for map_table
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_map_table;

  localparam int ARCH = 32;
  localparam int TW   = 6;
`ifdef MAP_TABLE_CDB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    string                       name;
    logic [TW-1:0]               r1p;
    logic                        r1r;
    logic [TW-1:0]               r2p;
    logic                        r2r;
    logic [TW-1:0]               op;
    logic [ARCH-1:0]             mrdy;
    logic [ARCH-1:0][TW-1:0]     marr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];
  exp_t e;

  logic [ARCH-1:0][TW-1:0] m_map;
  logic [ARCH-1:0]         m_rdy;

  map_table_if #(.ARCH_SIZE(ARCH), .PHYS_SIZE(64)) bus();

  map_table dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [191:0] act, logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every mid-cycle sample is a response
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, ".rs1_pr"},    192'(bus.rs1_pr),    192'(e.r1p));
      check({e.name, ".rs1_ready"}, 192'(bus.rs1_ready), 192'(e.r1r));
      check({e.name, ".rs2_pr"},    192'(bus.rs2_pr),    192'(e.r2p));
      check({e.name, ".rs2_ready"}, 192'(bus.rs2_ready), 192'(e.r2r));
      check({e.name, ".old_pr"},    192'(bus.old_pr),    192'(e.op));
      check({e.name, ".map_ready"}, 192'(bus.map_ready), 192'(e.mrdy));
      check({e.name, ".map_array"}, 192'(bus.map_array), 192'(e.marr));
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < ARCH; i++) begin
      m_map[i] = TW'(i);
      m_rdy[i] = 1'b1;
    end
  endfunction

  task automatic set_in(bit de, int dar, int npr, int r1, int r2, bit cv, int ct, bit rec);
    bus.dispatch_en      = de;
    bus.dispatch_dest_ar = 5'(dar);
    bus.dispatch_new_pr  = 6'(npr);
    bus.rs1_ar           = 5'(r1);
    bus.rs2_ar           = 5'(r2);
    bus.cdb_valid        = cv;
    bus.cdb_tag          = 6'(ct);
    bus.recover_en       = rec;
  endtask

  task automatic expect_now(string nm, int e1p, bit e1r, int e2p, bit e2r, int eop);
    exp_t x;
    x.name = nm;
    x.r1p  = TW'(e1p);
    x.r1r  = e1r;
    x.r2p  = TW'(e2p);
    x.r2r  = e2r;
    x.op   = TW'(eop);
    x.mrdy = m_rdy;
    x.marr = m_map;
    sb.push_back(x);
  endtask

  task automatic step(string nm, bit de, int dar, int npr, int r1, int r2, bit cv, int ct,
                      bit rec, int e1p, bit e1r, int e2p, bit e2r, int eop);
    set_in(de, dar, npr, r1, r2, cv, ct, rec);
    expect_now(nm, e1p, e1r, e2p, e2r, eop);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < ARCH; i++) bus.arch_map[i] = TW'(i);
    model_reset();
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("reset_read",   0, 0, 0,  5, 0, 0, 0, 0,  5, 1, 0, 1, 0);
    step("disp3_40",     1, 3, 40, 3, 3, 0, 0, 0,  3, 1, 3, 1, 3);
    m_map[3] = 6'd40; m_rdy[3] = 1'b0;
    step("read3_pend",   0, 0, 0,  3, 5, 0, 0, 0,  40, 0, 5, 1, 0);
    step("cdb40",        0, 0, 0,  3, 0, 1, 40, 0, 40, FWD, 0, 1, 0);
    m_rdy[3] = 1'b1;
    step("disp4_42",     1, 4, 42, 3, 0, 0, 0, 0,  40, 1, 0, 1, 4);
    m_map[4] = 6'd42; m_rdy[4] = 1'b0;
    step("disp_vs_cdb",  1, 3, 41, 3, 4, 1, 40, 0, 40, 1, 42, 0, 40);
    m_map[3] = 6'd41; m_rdy[3] = 1'b0;
    step("cdb_other",    1, 5, 43, 4, 5, 1, 42, 0, 42, FWD, 5, 1, 5);
    m_map[5] = 6'd43; m_rdy[5] = 1'b0; m_rdy[4] = 1'b1;
    step("cdb_eq_newpr", 1, 6, 44, 6, 3, 1, 44, 0, 6, 1, 41, 0, 6);
    m_map[6] = 6'd44; m_rdy[6] = 1'b0;
    step("disp_ar0",     1, 0, 50, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0);
    step("disp7_45",     1, 7, 45, 4, 5, 0, 0, 0,  42, 1, 43, 0, 7);
    m_map[7] = 6'd45; m_rdy[7] = 1'b0;
    step("disp9_46",     1, 9, 46, 7, 6, 0, 0, 0,  45, 0, 44, 0, 9);
    m_map[9] = 6'd46; m_rdy[9] = 1'b0;
    bus.arch_map[7] = 6'd33;
    step("recover",      1, 10, 47, 7, 9, 1, 41, 1, 45, 0, 46, 0, 10);
    model_reset(); m_map[7] = 6'd33;
    step("post_recover", 0, 10, 0, 7, 9, 0, 0, 0,  33, 1, 9, 1, 10);

    // Asynchronous reset lands mid-cycle with a dispatch pending
    set_in(1, 3, 55, 3, 7, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    expect_now("reset_mid", 3, 1, 7, 1, 3);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("after_reset",  0, 0, 0,  3, 7, 0, 0, 0,  3, 1, 7, 1, 0);

    repeat (3) @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/map_table.md
Name: map_table

Overview:
- Speculative register map table for the rename stage.
- Holds the current architectural-to-physical tag mapping and a per-entry ready bit.
- Answers source-operand lookups for dispatch and updates ready bits from CDB broadcasts.
- Restores the retirement map on recovery.
- Exports the full tag array and ready vector to the downstream tag-search CAM (array / array_valid inputs).

Parameters:
- ARCH_SIZE, `ARCH_REGFILE_SIZE (32): number of architectural registers.
- PHYS_SIZE, `PHYS_REGFILE_SIZE (64): number of physical registers.
- TAG_W, $clog2(PHYS_SIZE): physical tag width.
- AR_W, $clog2(ARCH_SIZE): architectural index width.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- dispatch_en  input  1  rename one instruction this cycle.
- dispatch_dest_ar  input  AR_W  destination architectural register.
- dispatch_new_pr  input  TAG_W  freshly allocated physical tag for the destination.
- rs1_ar  input  AR_W  source 1 architectural register.
- rs2_ar  input  AR_W  source 2 architectural register.
- rs1_pr  output  TAG_W  current tag mapped to rs1_ar.
- rs1_ready  output  1  rs1 value available.
- rs2_pr  output  TAG_W  current tag mapped to rs2_ar.
- rs2_ready  output  1  rs2 value available.
- old_pr  output  TAG_W  tag previously mapped to dispatch_dest_ar, sent to the ROB for freeing at retire.
- cdb_valid  input  1  CDB broadcast valid.
- cdb_tag  input  TAG_W  completing physical tag.
- recover_en  input  1  mispredict recovery.
- arch_map  input  ARCH_SIZE x TAG_W  retirement map snapshot.
- map_array  output  ARCH_SIZE x TAG_W  registered tag array, drives CAM array.
- map_ready  output  ARCH_SIZE  registered ready bits, drives CAM array_valid.

Behaviour:
- Reset (reset==0, asynchronous): map[i]=i for all i; ready[i]=1 for all i. Outputs follow combinationally from this state.
- Lookups are combinational from registered state (0-cycle latency):
  - rsN_pr = map[rsN_ar]; rsN_ready = ready[rsN_ar].
  - old_pr = map[dispatch_dest_ar].
  - Sources always see the pre-write mapping, so an instruction with rs == rd reads the old tag.
- AR 0 is hardwired:
  - Lookups of AR 0 return pr=0, ready=1.
  - Dispatch with dest_ar==0 writes nothing; old_pr=0.
  - Entry 0 stays map=0, ready=1 in all cases, including recovery.
- Dispatch (dispatch_en && dest_ar!=0): at the clock edge, map[dest_ar] <= dispatch_new_pr and ready[dest_ar] <= 0.
- CDB (cdb_valid): at the clock edge, every entry i with map[i]==cdb_tag gets ready[i] <= 1. At most one entry matches by construction; the match is a full parallel compare, not a priority search.
- Simultaneous dispatch and CDB on the same entry: dispatch wins (new tag, ready=0). CDB on other entries still applies in the same cycle.
- cdb_tag equal to dispatch_new_pr in the same cycle: the new entry stays not-ready (the tag was not mapped before the edge).
- Recovery (recover_en): at the clock edge, map[i] <= arch_map[i] and ready[i] <= 1 for all i>0.
  - Dispatch and CDB writes in that cycle are discarded.
  - Combinational outputs in the recovery cycle still reflect pre-recovery state; the consumer must not use them.
- Reset asserted mid-operation overrides everything immediately; no pending write survives.
- map_array and map_ready are direct register outputs with no combinational path from inputs.

Optional Feature:
- Macro: MAP_TABLE_CDB_FWD_EN.
- When defined: rsN_ready is additionally forced to 1 when cdb_valid && cdb_tag==map[rsN_ar] (same-cycle CDB bypass), so a dispatching consumer is not stuck waiting on a broadcast it missed.
- When undefined: rsN_ready reflects the registered bit only, and the consumer snoops the CDB itself.
- map_ready is unaffected in both cases.

Test Plan:
- Reset release, then read rs1_ar=5, rs2_ar=0 -> rs1_pr=5, rs1_ready=1, rs2_pr=0, rs2_ready=1; map_ready all ones.
- Dispatch dest_ar=3, new_pr=40 -> same cycle old_pr=3. Next cycle rs1_ar=3 gives rs1_pr=40, rs1_ready=0; map_ready[3]=0.
- After the previous step, cdb_valid with cdb_tag=40 -> next cycle ready[3]=1. With MAP_TABLE_CDB_FWD_EN, rs1_ready=1 in the broadcast cycle; without it, rs1_ready=0 in that cycle.
- Same cycle: dispatch dest_ar=3, new_pr=41 and cdb_tag=40 -> map[3]=41, ready[3]=0; no other entry changes.
- Dispatch dest_ar=0, new_pr=50 -> old_pr=0; entry 0 stays 0/ready; no state change.
- Dispatch AR7->45 and AR9->46, then recover_en with arch_map identity except arch_map[7]=33 -> map[7]=33, map[9]=9, all ready=1. A dispatch in the recovery cycle is discarded.
